// File: rtl/chase_tp_sched_pkg.sv
// Shared definitions for the Chase test-pattern scheduler: state encoding, code constants,
// per-pattern flip counts and default syndrome geometry.
package chase_tp_sched_pkg;

  localparam int unsigned SynW  = 10;
  localparam int unsigned NSyn  = 8;
  localparam int unsigned NErrW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StGen,
    StIssue,
    StWait
  } state_e;

  localparam logic [1:0] CodeT4 = 2'b10;

  // Flipped LRB count per pattern tag, 2 bits each: tag3=2, tag2=1, tag1=1, tag0=0.
  localparam logic [7:0] FlipTable = 8'b10_01_01_00;

  function automatic logic [1:0] flips_of(input logic [1:0] tag);
    return FlipTable[{tag, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/chase_tp_sched_if.sv
// Decoder-side bundle for chase_tp_sched: syndrome offer handshake and result return.
interface chase_tp_sched_if
  import chase_tp_sched_pkg::*;
#(
  parameter int unsigned SYN_W  = SynW,
  parameter int unsigned NSYN   = NSyn,
  parameter int unsigned NERR_W = NErrW
);
  logic [1:0]            code;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [SYN_W*NSYN-1:0] dec_S;
  logic [1:0]            dec_tag;
  logic                  res_valid;
  logic [1:0]            res_tag;
  logic                  res_fail;
  logic [NERR_W-1:0]     res_nerr;

  modport master (
    output code, dec_valid, dec_S, dec_tag,
    input  dec_ready, res_valid, res_tag, res_fail, res_nerr
  );

  modport slave (
    input  code, dec_valid, dec_S, dec_tag,
    output dec_ready, res_valid, res_tag, res_fail, res_nerr
  );
endinterface

// File: rtl/chase_best_sel.sv
// Metric of an incoming decoder result and whether it beats the current best
// (failed results never win; ties resolve to the lower tag).
module chase_best_sel
  import chase_tp_sched_pkg::*;
#(
  parameter int unsigned NERR_W = NErrW
) (
  input  logic [NERR_W:0]   best_metric_i,
  input  logic [1:0]        best_tag_i,
  input  logic [1:0]        res_tag_i,
  input  logic              res_fail_i,
  input  logic [NERR_W-1:0] res_nerr_i,
  output logic              take_o,
  output logic [NERR_W:0]   res_metric_o
);

  assign res_metric_o = {1'b0, res_nerr_i} + (NERR_W + 1)'(flips_of(res_tag_i));

  assign take_o = !res_fail_i &&
                  ((res_metric_o < best_metric_i) ||
                   ((res_metric_o == best_metric_i) && (res_tag_i < best_tag_i)));

endmodule

// File: rtl/chase_tp_sched.sv
// Chase test-pattern scheduler: captures four syndrome sets and shares one decoder among them.
// Optional early termination on a clean tp1 result is enabled by defining CHASE_EARLY_TERM_EN.
module chase_tp_sched
  import chase_tp_sched_pkg::*;
#(
  parameter int unsigned SYN_W  = SynW,
  parameter int unsigned NSYN   = NSyn,
  parameter int unsigned NERR_W = NErrW
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_code,
  output logic                  o_busy,
  output logic                  o_gen,
  input  logic                  i_tp_valid,
  input  logic [SYN_W*NSYN-1:0] i_S,
  input  logic [SYN_W*NSYN-1:0] i_tp2_S,
  input  logic [SYN_W*NSYN-1:0] i_tp3_S,
  input  logic [SYN_W*NSYN-1:0] i_tp4_S,
  chase_tp_sched_if.master      dec,
  output logic                  o_done,
  output logic [1:0]            o_best_tag,
  output logic                  o_best_fail
);

  localparam int unsigned SetW = SYN_W * NSYN;

  state_e            state_q, state_d;
  logic [1:0]        code_q, code_d;
  logic              gen_q;
  logic [SetW-1:0]   set_q [4];
  logic              capture;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        issued_q, issued_d;
  logic [3:0]        recv_q, recv_d;
  logic [NERR_W:0]   best_metric_q, best_metric_d;
  logic [1:0]        best_tag_q, best_tag_d;
  logic              done_q, done_d;
  logic [1:0]        out_tag_q, out_tag_d;
  logic              out_fail_q, out_fail_d;
  logic              hs, res_ok, take, early_stop;
  logic [NERR_W:0]   res_metric;

  assign hs     = dec.dec_valid && dec.dec_ready;
  assign res_ok = dec.res_valid && (state_q == StIssue || state_q == StWait) &&
                  issued_q[dec.res_tag] && !recv_q[dec.res_tag];

`ifdef CHASE_EARLY_TERM_EN
  assign early_stop = res_ok && (dec.res_tag == 2'd0) && !dec.res_fail && (dec.res_nerr == '0);
`else
  assign early_stop = 1'b0;
`endif

  chase_best_sel #(
    .NERR_W (NERR_W)
  ) u_best_sel (
    .best_metric_i (best_metric_q),
    .best_tag_i    (best_tag_q),
    .res_tag_i     (dec.res_tag),
    .res_fail_i    (dec.res_fail),
    .res_nerr_i    (dec.res_nerr),
    .take_o        (take),
    .res_metric_o  (res_metric)
  );

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    idx_d         = idx_q;
    issued_d      = issued_q;
    recv_d        = recv_q;
    best_metric_d = best_metric_q;
    best_tag_d    = best_tag_q;
    done_d        = 1'b0;
    out_tag_d     = out_tag_q;
    out_fail_d    = out_fail_q;
    capture       = 1'b0;

    if (res_ok) begin
      recv_d[dec.res_tag] = 1'b1;
      if (take) begin
        best_metric_d = res_metric;
        best_tag_d    = dec.res_tag;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d       = StGen;
          code_d        = i_code;
          idx_d         = 2'd0;
          issued_d      = '0;
          recv_d        = '0;
          best_metric_d = '1;
          best_tag_d    = 2'd0;
        end
      end
      StGen: begin
        if (i_tp_valid) begin
          capture = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (hs) begin
          issued_d[idx_q] = 1'b1;
          idx_d           = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StWait;
        end
        if (early_stop) state_d = StWait;
      end
      StWait: begin
        // All-ones metric is unreachable by a passing result, so it marks "nothing passed".
        if (recv_d == issued_q) begin
          state_d    = StIdle;
          done_d     = 1'b1;
          out_fail_d = (best_metric_d == '1);
          out_tag_d  = best_tag_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      code_q        <= '0;
      gen_q         <= 1'b0;
      set_q         <= '{default: '0};
      idx_q         <= '0;
      issued_q      <= '0;
      recv_q        <= '0;
      best_metric_q <= '1;
      best_tag_q    <= '0;
      done_q        <= 1'b0;
      out_tag_q     <= '0;
      out_fail_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      gen_q         <= (state_d == StGen);
      idx_q         <= idx_d;
      issued_q      <= issued_d;
      recv_q        <= recv_d;
      best_metric_q <= best_metric_d;
      best_tag_q    <= best_tag_d;
      done_q        <= done_d;
      out_tag_q     <= out_tag_d;
      out_fail_q    <= out_fail_d;
      if (capture) begin
        set_q[0] <= i_S;
        set_q[1] <= i_tp2_S;
        set_q[2] <= i_tp3_S;
        set_q[3] <= i_tp4_S;
      end
    end
  end

  assign o_busy        = (state_q != StIdle);
  assign o_gen         = gen_q;
  assign o_done        = done_q;
  assign o_best_tag    = out_tag_q;
  assign o_best_fail   = out_fail_q;
  assign dec.code      = code_q;
  assign dec.dec_valid = (state_q == StIssue);
  assign dec.dec_S     = set_q[idx_q];
  assign dec.dec_tag   = idx_q;

endmodule

// File: tb/tb_chase_tp_sched.sv
// Self-checking bench for chase_tp_sched: directed scenarios plus randomized runs against a
// transaction-level model of the winning-pattern rule.
module tb_chase_tp_sched;

  localparam int unsigned SW = 80;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic [1:0]    i_code = '0;
  logic          i_tp_valid = 1'b0;
  logic [SW-1:0] i_S = '0, i_tp2_S = '0, i_tp3_S = '0, i_tp4_S = '0;
  logic          o_busy, o_gen, o_done, o_best_fail;
  logic [1:0]    o_best_tag;

  chase_tp_sched_if #(.SYN_W(10), .NSYN(8), .NERR_W(3)) dif ();

  chase_tp_sched #(
    .SYN_W  (10),
    .NSYN   (8),
    .NERR_W (3)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_code      (i_code),
    .o_busy      (o_busy),
    .o_gen       (o_gen),
    .i_tp_valid  (i_tp_valid),
    .i_S         (i_S),
    .i_tp2_S     (i_tp2_S),
    .i_tp3_S     (i_tp3_S),
    .i_tp4_S     (i_tp4_S),
    .dec         (dif),
    .o_done      (o_done),
    .o_best_tag  (o_best_tag),
    .o_best_fail (o_best_fail)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Scenario configuration read by run_txn and the reference model.
  int            cfg_nerr  [4];
  bit            cfg_fail  [4];
  int            cfg_order [4];
  int            cfg_stall_tag, cfg_stall_len, cfg_dup_tag, cfg_dup_after;
  bit            cfg_rand_ready;
  logic [SW-1:0] cur_set [4];
  logic [1:0]    cur_code;
  int            flips [4] = '{0, 1, 1, 2};

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner from the rules: lowest nerr+flips among passing patterns, lowest tag on ties.
  function automatic void exp_best(output logic [1:0] tag, output logic fail);
    int best = 1000;
    tag  = 2'd0;
    fail = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (!cfg_fail[k] && (cfg_nerr[k] + flips[k] < best)) begin
        best = cfg_nerr[k] + flips[k];
        tag  = 2'(k);
        fail = 1'b0;
      end
    end
  endfunction

  task automatic check_reset_values(input string name);
    check({name, ":busy"},      SW'(o_busy),        SW'(0));
    check({name, ":gen"},       SW'(o_gen),         SW'(0));
    check({name, ":dec_valid"}, SW'(dif.dec_valid), SW'(0));
    check({name, ":done"},      SW'(o_done),        SW'(0));
    check({name, ":best_tag"},  SW'(o_best_tag),    SW'(0));
    check({name, ":best_fail"}, SW'(o_best_fail),   SW'(0));
    check({name, ":code"},      SW'(dif.code),      SW'(0));
    check({name, ":dec_S"},     dif.dec_S,          SW'(0));
    check({name, ":dec_tag"},   SW'(dif.dec_tag),   SW'(0));
  endtask

  task automatic drive_res(input int t, input int nerr, input bit fail);
    dif.res_valid = 1'b1;
    dif.res_tag   = 2'(t);
    dif.res_nerr  = 3'(nerr);
    dif.res_fail  = fail;
  endtask

  task automatic cfg_plain();
    for (int k = 0; k < 4; k++) begin
      cfg_order[k] = k;
      cfg_fail[k]  = 1'b0;
    end
    cfg_stall_tag  = 0;
    cfg_stall_len  = 0;
    cfg_dup_tag    = -1;
    cfg_dup_after  = 0;
    cfg_rand_ready = 1'b0;
  endtask

  task automatic cfg_random();
    for (int k = 0; k < 4; k++) begin
      cfg_nerr[k]  = int'($urandom_range(0, 7));
      cfg_fail[k]  = ($urandom_range(0, 3) == 0);
      cfg_order[k] = k;
    end
    for (int i = 3; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = cfg_order[i];
      cfg_order[i] = cfg_order[j];
      cfg_order[j] = t;
    end
    cfg_stall_tag  = int'($urandom_range(0, 3));
    cfg_stall_len  = int'($urandom_range(0, 4));
    cfg_rand_ready = 1'b1;
    if ($urandom_range(0, 1) == 1) begin
      cfg_dup_after = int'($urandom_range(1, 3));
      cfg_dup_tag   = cfg_order[$urandom_range(0, cfg_dup_after - 1)];
    end else begin
      cfg_dup_tag   = -1;
      cfg_dup_after = 0;
    end
`ifdef CHASE_EARLY_TERM_EN
    if (!cfg_fail[0] && cfg_nerr[0] == 0) cfg_nerr[0] = 1;
`endif
  endtask

  task automatic start_capture(input string name);
    for (int k = 0; k < 4; k++) cur_set[k] = {16'($urandom), $urandom, $urandom};
    cur_code = 2'($urandom);
    i_code   = cur_code;
    i_start  = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_code  = ~cur_code;
    check({name, ":busy"},     SW'(o_busy), SW'(1));
    check({name, ":gen_rise"}, SW'(o_gen),  SW'(1));
    repeat (2) @(negedge i_clk);
    i_tp_valid = 1'b1;
    i_S        = cur_set[0];
    i_tp2_S    = cur_set[1];
    i_tp3_S    = cur_set[2];
    i_tp4_S    = cur_set[3];
    @(negedge i_clk);
    i_tp_valid = 1'b0;
    i_S        = ~cur_set[0];
    i_tp2_S    = ~cur_set[1];
    i_tp3_S    = ~cur_set[2];
    i_tp4_S    = ~cur_set[3];
    check({name, ":gen_fall"},    SW'(o_gen),         SW'(0));
    check({name, ":first_offer"}, SW'(dif.dec_valid), SW'(1));
  endtask

  task automatic run_txn(input string name);
    int            next_tag = 0, nres = 0, stall_cnt = 0, done_cnt = 0, cyc = 0;
    int            first_hs = -1, last_hs = -1;
    bit            issued [4];
    bit            prev_stall = 1'b0, dup_pend = 1'b0, exp_done = 1'b0, hs, ready;
    logic [SW-1:0] prev_s = '0;
    logic [1:0]    prev_tag = '0, e_tag;
    logic          e_fail;
    for (int k = 0; k < 4; k++) issued[k] = 1'b0;
    start_capture(name);
    while (done_cnt == 0 && cyc < 300) begin
      check({name, ":done_timing"}, SW'(o_done), SW'(exp_done));
      if (o_done) begin
        done_cnt++;
      end else begin
        exp_done      = 1'b0;
        cyc++;
        dif.res_valid = 1'b0;
        if (prev_stall) begin
          check({name, ":tag_stable"}, SW'(dif.dec_tag), SW'(prev_tag));
          check({name, ":S_stable"},   dif.dec_S,        prev_s);
        end
        ready = cfg_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dif.dec_valid && int'(dif.dec_tag) == cfg_stall_tag && stall_cnt < cfg_stall_len) begin
          ready = 1'b0;
          stall_cnt++;
        end
        dif.dec_ready = ready;
        hs = dif.dec_valid && ready;
        if (hs) begin
          check({name, ":issue_tag"}, SW'(dif.dec_tag), SW'(next_tag));
          check({name, ":issue_S"},   dif.dec_S,        cur_set[next_tag & 3]);
          check({name, ":code"},      SW'(dif.code),    SW'(cur_code));
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
        if (dup_pend) begin
          drive_res(cfg_dup_tag, 0, 1'b0);
          dup_pend = 1'b0;
        end else if (nres < 4 && issued[cfg_order[nres]] && $urandom_range(0, 3) != 0) begin
          drive_res(cfg_order[nres], cfg_nerr[cfg_order[nres]], cfg_fail[cfg_order[nres]]);
          nres++;
          if (nres == cfg_dup_after && cfg_dup_tag >= 0) dup_pend = 1'b1;
          exp_done = (nres == 4);
        end else if (!issued[3] && $urandom_range(0, 7) == 0) begin
          drive_res(3, 0, 1'b0);  // tag not yet issued: must be ignored
        end
        if (hs && next_tag < 4) issued[next_tag] = 1'b1;
        if (hs) next_tag++;
        i_start    = ($urandom_range(0, 15) == 0);
        i_code     = 2'($urandom);
        i_tp_valid = ($urandom_range(0, 7) == 0);
        prev_stall = dif.dec_valid && !ready;
        prev_s     = dif.dec_S;
        prev_tag   = dif.dec_tag;
        @(negedge i_clk);
      end
    end
    i_start       = 1'b0;
    i_tp_valid    = 1'b0;
    dif.res_valid = 1'b0;
    dif.dec_ready = 1'b0;
    exp_best(e_tag, e_fail);
    check({name, ":done_seen"},  SW'(done_cnt),      SW'(1));
    check({name, ":issued_all"}, SW'(next_tag),      SW'(4));
    check({name, ":best_tag"},   SW'(o_best_tag),    SW'(e_tag));
    check({name, ":best_fail"},  SW'(o_best_fail),   SW'(e_fail));
    check({name, ":idle"},       SW'(o_busy),        SW'(0));
    if (!cfg_rand_ready && cfg_stall_len == 0)
      check({name, ":back_to_back"}, SW'(last_hs - first_hs), SW'(3));
    @(negedge i_clk);
    check({name, ":done_pulse"}, SW'(o_done),      SW'(0));
    check({name, ":best_held"},  SW'(o_best_tag),  SW'(e_tag));
    check({name, ":no_offer"},   SW'(dif.dec_valid), SW'(0));
  endtask

  task automatic reset_mid_issue();
    start_capture("rst");
    dif.dec_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    check("rst:pre_tag", SW'(dif.dec_tag), SW'(2));
    dif.dec_ready = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

`ifdef CHASE_EARLY_TERM_EN
  task automatic run_early();
    start_capture("early");
    dif.dec_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    check("early:tag2_offered", SW'(dif.dec_tag), SW'(2));
    dif.dec_ready = 1'b0;
    drive_res(0, 0, 1'b0);
    @(negedge i_clk);
    dif.res_valid = 1'b0;
    check("early:valid_drop", SW'(dif.dec_valid), SW'(0));
    check("early:no_done",    SW'(o_done),        SW'(0));
    drive_res(1, 2, 1'b0);
    @(negedge i_clk);
    dif.res_valid = 1'b0;
    check("early:done",      SW'(o_done),      SW'(1));
    check("early:best_tag",  SW'(o_best_tag),  SW'(0));
    check("early:best_fail", SW'(o_best_fail), SW'(0));
    dif.dec_ready = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      check("early:no_offer", SW'(dif.dec_valid), SW'(0));
    end
    dif.dec_ready = 1'b0;
  endtask
`endif

  initial begin
    dif.dec_ready = 1'b0;
    dif.res_valid = 1'b0;
    dif.res_tag   = '0;
    dif.res_fail  = 1'b0;
    dif.res_nerr  = '0;
    #1 i_rst_n = 1'b0;
    #20 check_reset_values("por");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    cfg_plain();
    cfg_nerr = '{3, 1, 2, 1};
    run_txn("nominal");

    cfg_plain();
    cfg_nerr      = '{2, 4, 0, 5};
    cfg_stall_tag = 2;
    cfg_stall_len = 5;
    run_txn("backpressure");

    cfg_plain();
    cfg_order     = '{3, 1, 0, 2};
    cfg_fail      = '{1'b1, 1'b1, 1'b1, 1'b0};
    cfg_nerr      = '{0, 2, 0, 1};
    cfg_dup_tag   = 1;
    cfg_dup_after = 2;
    run_txn("ooo_dup");

    cfg_plain();
    cfg_fail = '{1'b1, 1'b1, 1'b1, 1'b1};
    cfg_nerr = '{1, 0, 3, 2};
    run_txn("all_fail");

    cfg_plain();
    cfg_order = '{2, 0, 3, 1};
    cfg_nerr  = '{3, 1, 1, 1};
    run_txn("tie");

    reset_mid_issue();
    cfg_random();
    run_txn("after_rst");

`ifdef CHASE_EARLY_TERM_EN
    run_early();
`endif

    for (int n = 0; n < 16; n++) begin
      cfg_random();
      run_txn($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
